// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler
//   Four-floor SCAN request scheduler. It latches call buttons into pending
//   flags, picks the next target floor in the current sweep direction, and
//   holds the door open for a dwell period on arrival.
//
// Ports
//   clk             in   single clock, rising edge
//   reset           in   asynchronous, active-high
//   call_btn[3:0]   in   raw floor call buttons (async, level)
//   present_floor   in   one-hot current floor from the floor controller
//   requested_floor out  one-hot target floor (registered)
//   pending[3:0]    out  latched call flags (registered)
//   door_open       out  door dwell active (registered)
//   dir_up          out  sweep direction, 1 = up (registered)
//   busy            out  not IDLE or any call pending
module floor_request_scheduler #(
  parameter int unsigned DWELL_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] call_btn,
  input  logic [3:0] present_floor,
  output logic [3:0] requested_floor,
  output logic [3:0] pending,
  output logic       door_open,
  output logic       dir_up,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    MOVING,
    DOOR
  } state_e;

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] sync1_q, sync2_q, prev_q;
  logic [3:0] pending_q, pending_d;
  logic [3:0] req_q, req_d;
  logic       door_q, door_d;
  logic       dir_q, dir_d;
  logic [7:0] dwell_q, dwell_d;

  logic [3:0] rise;
  logic [3:0] set_mask;
  logic [3:0] clr;
  logic       onehot;
  logic [1:0] pidx;
  logic [5:0] sc;

  // SCAN target pick: {found, new_dir, one-hot target}. Prefers the current
  // direction; when nothing lies that way the direction flips in the same
  // evaluation so the reversal costs no extra cycle.
  function automatic logic [5:0] scan(input logic dir, input logic [3:0] pend,
                                      input logic [1:0] idx);
    logic       up_f, dn_f;
    logic [3:0] up_t, dn_t;
    up_f = 1'b0;
    dn_f = 1'b0;
    up_t = '0;
    dn_t = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (pend[i] && (i > int'(idx)) && !up_f) begin
        up_f = 1'b1;
        up_t = 4'b0001 << i;
      end
      if (pend[i] && (i < int'(idx))) begin
        dn_f = 1'b1;
        dn_t = 4'b0001 << i;
      end
    end
    if (dir) begin
      if (up_f)      scan = {1'b1, 1'b1, up_t};
      else if (dn_f) scan = {1'b1, 1'b0, dn_t};
      else           scan = {1'b0, dir, 4'b0000};
    end else begin
      if (dn_f)      scan = {1'b1, 1'b0, dn_t};
      else if (up_f) scan = {1'b1, 1'b1, up_t};
      else           scan = {1'b0, dir, 4'b0000};
    end
  endfunction

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    onehot = (present_floor != '0) &&
             ((present_floor & (present_floor - 4'd1)) == '0);
    pidx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (present_floor[i]) pidx = 2'(i);
    end
    // Leaving IDLE uses an up-first pick, which yields dir_up = "anything above".
    sc = scan((state_q == IDLE) ? 1'b1 : dir_q, pending_q, pidx);

    // A press of the current floor's button during the dwell only extends it.
    set_mask = rise;
    if (state_q == DOOR && onehot) set_mask = rise & ~present_floor;

    clr     = '0;
    state_d = state_q;
    req_d   = req_q;
    dir_d   = dir_q;
    door_d  = door_q;
    dwell_d = dwell_q;

    // Non-one-hot position: no arrival can be judged, so the FSM freezes.
    if (onehot) begin
      case (state_q)
        IDLE: begin
          req_d  = present_floor;
          door_d = 1'b0;
          if ((pending_q & present_floor) != '0) begin
            state_d = DOOR;
            clr     = present_floor;
            dwell_d = DWELL_LOAD;
            door_d  = 1'b1;
          end else if (pending_q != '0) begin
            state_d = MOVING;
            dir_d   = sc[4];
            req_d   = sc[3:0];
          end
        end
        MOVING: begin
          if (present_floor == req_q && pending_q[pidx]) begin
            state_d = DOOR;
            clr     = present_floor;
            dwell_d = DWELL_LOAD;
            door_d  = 1'b1;
            req_d   = present_floor;
          end else if (pending_q == '0) begin
            state_d = IDLE;
            req_d   = present_floor;
          end else if (sc[5]) begin
            dir_d = sc[4];
            req_d = sc[3:0];
          end else begin
            // Only the current floor is pending: aim here so it is served next.
            req_d = present_floor;
          end
        end
        DOOR: begin
          door_d = 1'b1;
          req_d  = present_floor;
          if ((rise & present_floor) != '0) begin
            dwell_d = DWELL_LOAD;
          end else if (dwell_q != '0) begin
            dwell_d = dwell_q - 8'd1;
          end else begin
            door_d = 1'b0;
            if (pending_q == '0) begin
              state_d = IDLE;
            end else begin
              state_d = MOVING;
              if (sc[5]) begin
                dir_d = sc[4];
                req_d = sc[3:0];
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Clear after set: a same-edge arrival clear wins over a new call.
    pending_d = (pending_q | set_mask) & ~clr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      req_q     <= 4'b0001;
      door_q    <= 1'b0;
      dir_q     <= 1'b1;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= call_btn;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
      req_q     <= req_d;
      door_q    <= door_d;
      dir_q     <= dir_d;
      dwell_q   <= dwell_d;
    end
  end

  assign requested_floor = req_q;
  assign pending         = pending_q;
  assign door_open       = door_q;
  assign dir_up          = dir_q;
  assign busy            = (state_q != IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_floor_request_scheduler.sv
module tb_floor_request_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] call_btn = 4'b0000;
  logic [3:0] present_floor = 4'b0001;
  logic [3:0] requested_floor;
  logic [3:0] pending;
  logic       door_open;
  logic       dir_up;
  logic       busy;

  floor_request_scheduler #(.DWELL_CYCLES(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .call_btn        (call_btn),
    .present_floor   (present_floor),
    .requested_floor (requested_floor),
    .pending         (pending),
    .door_open       (door_open),
    .dir_up          (dir_up),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation word: {requested[3:0], pending[3:0], door, dir, busy}
  localparam logic [10:0] M_ALL  = 11'h7FF;
  localparam logic [10:0] M_PEND = 11'h078;
  localparam logic [10:0] M_DOOR = 11'h004;
  localparam logic [10:0] M_BUSY = 11'h001;

  typedef struct {
    int          cyc;
    string       name;
    logic [10:0] val;
    logic [10:0] mask;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic void push_exp(input int c, input string n,
                                   input logic [3:0] r, input logic [3:0] p,
                                   input logic d, input logic u, input logic b,
                                   input logic [10:0] m);
    exp_t e;
    e.cyc  = c;
    e.name = n;
    e.val  = {r, p, d, u, b};
    e.mask = m;
    sb.push_back(e);
  endfunction

  // Monitor: every expectation is tied to the clock edge after which it must
  // hold; it is popped and compared at the following falling edge.
  always @(negedge clk) begin
    logic [10:0] obs;
    exp_t e;
    obs = {requested_floor, pending, door_open, dir_up, busy};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.cyc != cyc || ((obs ^ e.val) & e.mask) !== 11'h000) begin
        bad++;
        $display("FAIL %s cyc=%0d actual=%b required=%b mask=%b",
                 e.name, cyc, obs, e.val, e.mask);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] pf);
    @(negedge clk);
    reset = 1'b1;
    call_btn = 4'b0000;
    present_floor = pf;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  int c0;

  initial begin
    // Reset values and first call latency
    @(negedge clk);
    push_exp(cyc + 1, "rst_hold", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, M_ALL);
    do_reset(4'b0001);
    c0 = cyc;
    push_exp(c0 + 1, "idle_after_rst", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, M_ALL);
    push_exp(c0 + 2, "no_early_pend", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, M_PEND | M_BUSY);
    push_exp(c0 + 3, "pend_set", 4'b0001, 4'b0100, 1'b0, 1'b1, 1'b1, M_ALL);
    push_exp(c0 + 4, "move_up", 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1, M_ALL);
    push_exp(c0 + 6, "held_no_retrig", 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1, M_ALL);
    call_btn = 4'b0100;
    wait_cyc(c0 + 3);
    call_btn = 4'b0000;
    wait_cyc(c0 + 6);

    // Two calls, serve the nearer, dwell, continue; then reversal and retarget
    do_reset(4'b0001);
    c0 = cyc;
    push_exp(c0 + 4, "scan_first", 4'b0010, 4'b1010, 1'b0, 1'b1, 1'b1, M_ALL);
    push_exp(c0 + 5, "arrive_f1", 4'b0010, 4'b1000, 1'b1, 1'b1, 1'b1, M_ALL);
    for (int k = 6; k <= 12; k++)
      push_exp(c0 + k, "door_f1", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, M_DOOR);
    push_exp(c0 + 13, "next_f3", 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b1, M_ALL);
    push_exp(c0 + 16, "no_retarget_below", 4'b1000, 4'b1001, 1'b0, 1'b1, 1'b1, M_ALL);
    push_exp(c0 + 17, "arrive_f3", 4'b1000, 4'b0001, 1'b1, 1'b1, 1'b1, M_ALL);
    push_exp(c0 + 24, "door_f3_end", 4'b1000, 4'b0001, 1'b1, 1'b1, 1'b1, M_ALL);
    push_exp(c0 + 25, "dir_flip", 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, M_ALL);
    push_exp(c0 + 28, "pend_mid", 4'b0001, 4'b0101, 1'b0, 1'b0, 1'b1, M_ALL);
    push_exp(c0 + 29, "retarget_f2", 4'b0100, 4'b0101, 1'b0, 1'b0, 1'b1, M_ALL);
    call_btn = 4'b1010;
    wait_cyc(c0 + 1);
    call_btn = 4'b0000;
    wait_cyc(c0 + 4);
    present_floor = 4'b0010;
    wait_cyc(c0 + 13);
    call_btn = 4'b0001;
    wait_cyc(c0 + 14);
    call_btn = 4'b0000;
    wait_cyc(c0 + 16);
    present_floor = 4'b1000;
    wait_cyc(c0 + 25);
    call_btn = 4'b0100;
    wait_cyc(c0 + 26);
    call_btn = 4'b0000;
    wait_cyc(c0 + 29);

    // Dwell restart from a same-floor press at count 2: 6 + 8 door cycles
    do_reset(4'b0100);
    c0 = cyc;
    push_exp(c0 + 3, "idle_pend_here", 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1, M_ALL);
    for (int k = 4; k <= 17; k++)
      push_exp(c0 + k, "door_reload", 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, M_ALL);
    push_exp(c0 + 18, "door_done", 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, M_ALL);
    call_btn = 4'b0100;
    wait_cyc(c0 + 1);
    call_btn = 4'b0000;
    wait_cyc(c0 + 7);
    call_btn = 4'b0100;
    wait_cyc(c0 + 8);
    call_btn = 4'b0000;
    wait_cyc(c0 + 18);

    // Invalid position holds the FSM; async reset mid-DOOR
    do_reset(4'b0001);
    c0 = cyc;
    push_exp(c0 + 3, "nohot_zero", 4'b0001, 4'b0010, 1'b0, 1'b1, 1'b1, M_ALL);
    push_exp(c0 + 5, "nohot_hold", 4'b0001, 4'b0010, 1'b0, 1'b1, 1'b1, M_ALL);
    push_exp(c0 + 7, "nohot_multi", 4'b0001, 4'b0010, 1'b0, 1'b1, 1'b1, M_ALL);
    push_exp(c0 + 8, "door_f1b", 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, M_ALL);
    call_btn = 4'b0010;
    present_floor = 4'b0000;
    wait_cyc(c0 + 1);
    call_btn = 4'b0000;
    wait_cyc(c0 + 5);
    present_floor = 4'b0110;
    wait_cyc(c0 + 7);
    present_floor = 4'b0010;
    wait_cyc(c0 + 10);
    @(posedge clk);
    #2;
    reset = 1'b1;
    push_exp(cyc, "async_rst", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, M_ALL);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain_timeout actual=%0d left required=0", sb.size());
      total += sb.size();
      bad   += sb.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/floor_request_scheduler.md
FLOOR_REQUEST_SCHEDULER -- requirements
Module: floor_request_scheduler

Interface
REQ-001 Parameter: DWELL_CYCLES, default 8, door-open dwell length in clk cycles; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 call_btn  input  4  raw floor call buttons; bit i = floor i; asynchronous to clk; level-sensitive.
REQ-005 present_floor  input  4  one-hot current floor from the downstream floor controller; bit i = floor i.
REQ-006 requested_floor  output  4  one-hot target floor to the downstream controller; registered.
REQ-007 pending  output  4  registered latched call flags; bit i = floor i.
REQ-008 door_open  output  1  high while the door dwell is active; registered.
REQ-009 dir_up  output  1  current sweep direction; 1 = up, 0 = down; registered.
REQ-010 busy  output  1  high when the state is not IDLE or pending is non-zero; combinational from registers.

Function
REQ-011 Each call_btn bit SHALL pass through a two-flop synchronizer, followed by a registered rising-edge detector.
REQ-012 A rising edge on call_btn[i] sampled at edge k SHALL set pending[i] at edge k+2; a held button SHALL NOT re-trigger.
REQ-013 The FSM SHALL have exactly three states: IDLE, MOVING, DOOR.
REQ-014 IDLE: requested_floor = present_floor, and door_open = 0.
REQ-015 IDLE with pending[present] = 1 -> DOOR next cycle; pending[present] is cleared on that edge.
REQ-016 IDLE with any other pending bit set -> MOVING; dir_up = 1 if any pending bit is above present, else 0.
REQ-017 Target selection (MOVING), SCAN policy:
  - dir_up = 1: requested_floor = lowest pending floor above present.
  - dir_up = 0: requested_floor = highest pending floor below present.
  - No pending floor in the current direction: invert dir_up and apply the same rule in the new direction on the same edge.
REQ-018 MOVING with present_floor == requested_floor and pending[present] = 1 -> DOOR; clear pending[present]; load the dwell counter with DWELL_CYCLES-1.
REQ-019 DOOR: door_open = 1 and requested_floor is held at present_floor. The counter decrements once per cycle. At counter = 0:
  - pending = 0 -> IDLE.
  - pending != 0 -> MOVING, with the target re-evaluated per REQ-017.
REQ-020 A rise on the current floor's button during DOOR SHALL reload the dwell counter and SHALL NOT set pending.
REQ-021 If a set and a clear hit the same pending bit on the same edge, the clear SHALL win.
REQ-022 present_floor not one-hot (zero or multiple bits): no arrival is detected; the FSM and requested_floor hold; pending still accepts new calls.
REQ-023 A new call arriving in MOVING SHALL retarget on the next edge only if it lies between present and the current target in the sweep direction.
REQ-024 door_open, dir_up and requested_floor SHALL change only on clk edges or on reset; no combinational path from call_btn to any output.

Reset
REQ-025 While reset is high:
  - State = IDLE.
  - pending = 4'b0000, requested_floor = 4'b0001, door_open = 0, dir_up = 1, busy = 0.
  - Synchronizer, edge and dwell registers = 0.
REQ-026 Reset asserted mid-MOVING or mid-DOOR SHALL abort the operation and discard all pending calls.
REQ-027 After reset deasserts, the first call_btn edge SHALL be accepted per REQ-012, with no spurious call from pre-reset button levels. The edge register initializes to 0, so a button already held at release registers as one call.

Verification
REQ-028 Reset, present = 0001, pulse call_btn = 0100 for 3 cycles -> pending = 0100 two edges after the first sample; next cycle MOVING, dir_up = 1, requested_floor = 0100.
REQ-029 Present = 0001, pending {floor 1, floor 3} -> requested_floor = 0010; drive present = 0010 -> door_open = 1 for exactly 8 cycles, pending = 1000; then requested_floor = 1000.
REQ-030 Present = 1000, dir_up = 1, pending = 0001 -> dir_up flips to 0 and requested_floor = 0001 on the same edge.
REQ-031 During DOOR at floor 2, pulse call_btn[2] at dwell count 2 -> dwell restarts; total door_open = 6+8 cycles; pending[2] stays 0.
REQ-032 Present = 0000 or 0110 with pending = 0010 -> requested_floor unchanged, no DOOR entry; assert reset mid-DOOR -> all outputs return to REQ-025 values asynchronously.
